// File: rtl/cpu_rf_pkg.sv
// Shared register-file definitions: depth, address width, address and one-hot
// enable types, plus a helper that turns an address into a one-hot vector.
package cpu_rf_pkg;

  localparam int RF_DEPTH  = 16;
  localparam int RF_ADDR_W = 4;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DEPTH-1:0]  rf_onehot_t;

  // Turn a register address into a single set bit at that position.
  function automatic rf_onehot_t rf_onehot(input rf_addr_t a);
    rf_onehot_t r;
    r    = {RF_DEPTH{1'b0}};
    r[a] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_4to16.sv
// 4-to-16 one-hot decoder with an enable; all outputs are low when disabled.
module decoder_4to16
  import cpu_rf_pkg::*;
(
  input  logic       en,
  input  rf_addr_t   addr,
  output rf_onehot_t dec
);

  // One-hot decode of addr, gated by en.
  always_comb begin
    dec = {RF_DEPTH{1'b0}};
    if (en) begin
      dec = rf_onehot(addr);
    end else begin
      dec = {RF_DEPTH{1'b0}};
    end
  end

endmodule

// File: rtl/rf_read_port.sv
// One combinational read port: selects a register and its busy bit.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the addressed
// register is forwarded, and the busy bit follows the write unless the
// same register is also being reserved in that cycle.
module rf_read_port
  import cpu_rf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  rf_addr_t         rd_addr,
  input  logic [WIDTH-1:0] regs [RF_DEPTH],
  input  rf_onehot_t       busy_vec,
`ifdef REGFILE_BYPASS_EN
  input  logic             fwd_en,
  input  rf_addr_t         fwd_addr,
  input  logic [WIDTH-1:0] fwd_data,
  input  logic             rsv_live,
  input  rf_addr_t         rsv_addr,
`endif
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_busy
);

  // Register and scoreboard select, with optional write-through forwarding.
  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy_vec[rd_addr];
`ifdef REGFILE_BYPASS_EN
    if (fwd_en && (fwd_addr == rd_addr)) begin
      rd_data = fwd_data;
      rd_busy = rsv_live && (rsv_addr == rd_addr);
    end else begin
      rd_data = regs[rd_addr];
      rd_busy = busy_vec[rd_addr];
    end
`endif
  end

endmodule

// File: rtl/regfile_16x.sv
// 16-entry register file: one synchronous write port, two combinational read
// ports and a per-register busy scoreboard for issue-stage stalls.
// Optional macro REGFILE_BYPASS_EN adds write-through forwarding on reads.
module regfile_16x
  import cpu_rf_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [RF_ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rsv_en,
  input  logic [RF_ADDR_W-1:0] rsv_addr,
  input  logic [RF_ADDR_W-1:0] rs1_addr,
  input  logic [RF_ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]     rs1_data,
  output logic [WIDTH-1:0]     rs2_data,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [RF_DEPTH-1:0]  busy_vec
);

  // R0 is hardwired to zero when ZERO_R0 is set: its write and reserve
  // enables are masked off so it never changes and never goes busy.
  localparam rf_onehot_t KEEP_MASK = ZERO_R0 ? 16'hFFFE : 16'hFFFF;

  rf_onehot_t       wr_dec_s;
  rf_onehot_t       rsv_dec_s;
  rf_onehot_t       wr_hot_s;
  rf_onehot_t       rsv_hot_s;
  rf_onehot_t       busy_d;
  rf_onehot_t       busy_q;
  logic [WIDTH-1:0] regs_d [RF_DEPTH];
  logic [WIDTH-1:0] regs_q [RF_DEPTH];

  decoder_4to16 u_wr_dec (
    .en   (wr_en),
    .addr (wr_addr),
    .dec  (wr_dec_s)
  );

  decoder_4to16 u_rsv_dec (
    .en   (rsv_en),
    .addr (rsv_addr),
    .dec  (rsv_dec_s)
  );

  assign wr_hot_s  = wr_dec_s & KEEP_MASK;
  assign rsv_hot_s = rsv_dec_s & KEEP_MASK;

  // Next register contents: the one-hot write enable selects the target.
  always_comb begin
    for (int i = 0; i < RF_DEPTH; i++) begin
      if (wr_hot_s[i]) begin
        regs_d[i] = wr_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Next scoreboard: a reservation sets, a write clears, set wins on a tie
  // because the newer producer supersedes the one being written back.
  always_comb begin
    busy_d = rsv_hot_s | (busy_q & ~wr_hot_s);
  end

  // Register array and scoreboard state; reset discards any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      busy_q <= {RF_DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed while reset is held so reads stay at zero.
  logic fwd_en_s;
  logic rsv_live_s;
  assign fwd_en_s   = rst_n && (wr_hot_s != 16'h0000);
  assign rsv_live_s = (rsv_hot_s != 16'h0000);
`endif

  rf_read_port #(.WIDTH(WIDTH)) u_rd1 (
    .rd_addr  (rs1_addr),
    .regs     (regs_q),
    .busy_vec (busy_q),
`ifdef REGFILE_BYPASS_EN
    .fwd_en   (fwd_en_s),
    .fwd_addr (wr_addr),
    .fwd_data (wr_data),
    .rsv_live (rsv_live_s),
    .rsv_addr (rsv_addr),
`endif
    .rd_data  (rs1_data),
    .rd_busy  (rs1_busy)
  );

  rf_read_port #(.WIDTH(WIDTH)) u_rd2 (
    .rd_addr  (rs2_addr),
    .regs     (regs_q),
    .busy_vec (busy_q),
`ifdef REGFILE_BYPASS_EN
    .fwd_en   (fwd_en_s),
    .fwd_addr (wr_addr),
    .fwd_data (wr_data),
    .rsv_live (rsv_live_s),
    .rsv_addr (rsv_addr),
`endif
    .rd_data  (rs2_data),
    .rd_busy  (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_16x.sv
// Scoreboard bench for regfile_16x (ZERO_R0=1). Stimulus pushes hand-computed
// expectations into a queue; a monitor on the falling edge pops and compares.
module tb_regfile_16x;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [15:0] busy_vec;

  regfile_16x #(.WIDTH(32), .ZERO_R0(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic [15:0] bv;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input int step, input string what,
                     input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL step %0d %s: got %h want %h", step, what, act, want);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk(mon_e.step, "rs1_data", rs1_data, mon_e.d1);
      chk(mon_e.step, "rs2_data", rs2_data, mon_e.d2);
      chk(mon_e.step, "rs1_busy", {31'd0, rs1_busy}, {31'd0, mon_e.b1});
      chk(mon_e.step, "rs2_busy", {31'd0, rs2_busy}, {31'd0, mon_e.b2});
      chk(mon_e.step, "busy_vec", {16'd0, busy_vec}, {16'd0, mon_e.bv});
    end
  end

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic re, input logic [3:0] ra,
                       input logic [3:0] a1, input logic [3:0] a2);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = ra;
    rs1_addr = a1;
    rs2_addr = a2;
  endtask

  task automatic expect_out(input int step, input logic [31:0] d1, input logic [31:0] d2,
                            input logic b1, input logic b2, input logic [15:0] bv);
    exp_t e;
    e.step = step;
    e.d1   = d1;
    e.d2   = d2;
    e.b1   = b1;
    e.b2   = b2;
    e.bv   = bv;
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    next_cycle();

    // Reset held: every address on both ports reads zero, nothing busy.
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'(a), 4'(15 - a));
      expect_out(100 + a, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);
      next_cycle();
    end
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd1, 4'd15);
    expect_out(1, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);
    next_cycle();

    // Write r5, same-cycle read: forwarded only with bypass.
    drive(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'd5, 4'd5);
    expect_out(2, BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 1'b0, 1'b0, 16'h0000);
    next_cycle();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd5);
    expect_out(3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0000);
    next_cycle();

    // Write and reserve R0: both dropped.
    drive(1'b1, 4'd0, 32'h1234, 1'b1, 4'd0, 4'd0, 4'd5);
    expect_out(4, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0000);
    next_cycle();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_out(5, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);
    next_cycle();

    // Reserve r7, then write it back.
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd5, 4'd7);
    expect_out(6, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 16'h0000);
    next_cycle();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd7);
    expect_out(7, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 16'h0080);
    next_cycle();
    drive(1'b1, 4'd7, 32'hA5, 1'b0, 4'd0, 4'd7, 4'd7);
    expect_out(8, BYP ? 32'hA5 : 32'h0, BYP ? 32'hA5 : 32'h0, !BYP, !BYP, 16'h0080);
    next_cycle();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd7);
    expect_out(9, 32'hA5, 32'hA5, 1'b0, 1'b0, 16'h0000);
    next_cycle();

    // Reserve r3, then reserve+write r3 together: set wins.
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd3, 4'd3);
    expect_out(10, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);
    next_cycle();
    drive(1'b1, 4'd3, 32'h77, 1'b1, 4'd3, 4'd3, 4'd3);
    expect_out(11, BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, 1'b1, 1'b1, 16'h0008);
    next_cycle();
    // Re-reserving a busy register keeps it busy, no counting.
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd3, 4'd3);
    expect_out(12, 32'h77, 32'h77, 1'b1, 1'b1, 16'h0008);
    next_cycle();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd3);
    expect_out(13, 32'h77, 32'h77, 1'b1, 1'b1, 16'h0008);
    next_cycle();
    drive(1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 4'd3, 4'd3);
    expect_out(14, BYP ? 32'h33 : 32'h77, BYP ? 32'h33 : 32'h77, !BYP, !BYP, 16'h0008);
    next_cycle();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd3);
    expect_out(15, 32'h33, 32'h33, 1'b0, 1'b0, 16'h0000);
    next_cycle();

    // Reserve r2 and write r9 in the same cycle.
    drive(1'b1, 4'd9, 32'h999, 1'b1, 4'd2, 4'd2, 4'd9);
    expect_out(16, 32'h0, BYP ? 32'h999 : 32'h0, 1'b0, 1'b0, 16'h0000);
    next_cycle();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd2, 4'd9);
    expect_out(17, 32'h0, 32'h999, 1'b1, 1'b0, 16'h0004);
    next_cycle();

    // Write r4 and reserve r6, then an asynchronous reset mid-cycle.
    drive(1'b1, 4'd4, 32'h4444, 1'b1, 4'd6, 4'd4, 4'd6);
    expect_out(18, BYP ? 32'h4444 : 32'h0, 32'h0, 1'b0, 1'b0, 16'h0004);
    next_cycle();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd6);
    expect_out(19, 32'h4444, 32'h0, 1'b0, 1'b1, 16'h0044);
    next_cycle();
    drive(1'b1, 4'd4, 32'hBAD, 1'b1, 4'd4, 4'd4, 4'd6);
    #2;
    rst_n = 1'b0;
    expect_out(20, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd9);
    expect_out(21, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);
    next_cycle();

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      next_cycle();
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
